// File: rtl/gamepad_responder.sv
// Pad-side end of the GLatch/GPulse gamepad link: synchronizes the strobes and
// serializes the 8-bit button word onto GamePadData exactly as a physical pad.
//
// state | meaning
// IDLE  | no frame yet; line at released level, pulses ignored
// LOAD  | latch high; Buttons reloaded every cycle (transparent)
// SHIFT | latch low; each pulse rise advances to the next bit
// TAIL  | all 8 bits read; line held at the pressed level
module gamepad_responder #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       GLatch,
  input  logic       GPulse,
  input  logic [7:0] Buttons,
  output logic       GamePadData,
  output logic [3:0] BitCount,
  output logic       FrameDone,
  output logic       Error
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] TAIL  = 2'd3;

  localparam logic releasedLevel = ACTIVE_LOW;
  localparam logic pressedLevel  = !ACTIVE_LOW;
  localparam logic [3:0] lastBit  = 4'd7;
  localparam logic [3:0] tailCount = 4'd8;

  logic latchS1, latchS2, latchS3;
  logic pulseS1, pulseS2, pulseS3;
  logic latchRise, pulseRise;

  logic [1:0] state, stateNext;
  logic [7:0] shiftReg, shiftNext;
  logic [3:0] countNext;
  logic       dataNext;
  logic       doneNext;
  logic       errorNext;

  // s1/s2 resolve metastability on the asynchronous strobes; s3 is edge history
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      latchS1 <= 1'b0;
      latchS2 <= 1'b0;
      latchS3 <= 1'b0;
      pulseS1 <= 1'b0;
      pulseS2 <= 1'b0;
      pulseS3 <= 1'b0;
    end else begin
      latchS1 <= GLatch;
      latchS2 <= latchS1;
      latchS3 <= latchS2;
      pulseS1 <= GPulse;
      pulseS2 <= pulseS1;
      pulseS3 <= pulseS2;
    end
  end

  assign latchRise = latchS2 & ~latchS3;
  assign pulseRise = pulseS2 & ~pulseS3;

  always_comb begin
    stateNext = state;
    shiftNext = shiftReg;
    countNext = BitCount;
    dataNext  = GamePadData;
    doneNext  = 1'b0;
    errorNext = Error;

    if (latchRise) begin
      // A latch restarts the frame from any state; a coincident pulse is a protocol error
      stateNext = LOAD;
      shiftNext = Buttons;
      countNext = 4'd0;
      dataNext  = Buttons[0] ^ ACTIVE_LOW;
      errorNext = pulseRise;
    end else begin
      case (state)
        IDLE: begin
          dataNext  = releasedLevel;
          countNext = 4'd0;
        end
        LOAD: begin
          countNext = 4'd0;
          if (pulseRise) begin
            errorNext = 1'b1;
          end
          if (!latchS2) begin
            stateNext = SHIFT;
          end else begin
            shiftNext = Buttons;
            dataNext  = Buttons[0] ^ ACTIVE_LOW;
          end
        end
        SHIFT: begin
          if (pulseRise) begin
            shiftNext = {1'b0, shiftReg[7:1]};
            if (BitCount == lastBit) begin
              stateNext = TAIL;
              countNext = tailCount;
              doneNext  = 1'b1;
              dataNext  = pressedLevel;
            end else begin
              countNext = BitCount + 4'd1;
              dataNext  = shiftReg[1] ^ ACTIVE_LOW;
            end
          end
        end
        TAIL: begin
          dataNext  = pressedLevel;
          countNext = tailCount;
        end
        default: begin
          stateNext = IDLE;
          dataNext  = releasedLevel;
          countNext = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      shiftReg    <= 8'h00;
      BitCount    <= 4'd0;
      GamePadData <= releasedLevel;
      FrameDone   <= 1'b0;
      Error       <= 1'b0;
    end else begin
      state       <= stateNext;
      shiftReg    <= shiftNext;
      BitCount    <= countNext;
      GamePadData <= dataNext;
      FrameDone   <= doneNext;
      Error       <= errorNext;
    end
  end

endmodule

// File: tb/tb_gamepad_responder.sv
// Bench for gamepad_responder: one active-low and one active-high pad driven by
// the same strobes, checked against a frame-level model of what a pad should show.
module tb_gamepad_responder;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       GLatch = 1'b0;
  logic       GPulse = 1'b0;
  logic [7:0] Buttons = 8'h00;

  logic       dataH, doneH, errH;
  logic [3:0] cntH;
  logic       dataL, doneL, errL;
  logic [3:0] cntL;

  int compCount = 0;
  int errCount  = 0;
  int fdH = 0;
  int fdL = 0;
  int fdBad = 0;

  gamepad_responder #(.ACTIVE_LOW(1'b1)) dutH (
    .Clock(Clock), .Reset(Reset), .GLatch(GLatch), .GPulse(GPulse),
    .Buttons(Buttons), .GamePadData(dataH), .BitCount(cntH),
    .FrameDone(doneH), .Error(errH)
  );

  gamepad_responder #(.ACTIVE_LOW(1'b0)) dutL (
    .Clock(Clock), .Reset(Reset), .GLatch(GLatch), .GPulse(GPulse),
    .Buttons(Buttons), .GamePadData(dataL), .BitCount(cntL),
    .FrameDone(doneL), .Error(errL)
  );

  always #5 Clock = ~Clock;

  // Each sampled high cycle counts once, so a stretched pulse shows up as an extra frame
  always @(negedge Clock) begin
    if (doneH) begin
      fdH++;
      if (cntH != 4'd8) fdBad++;
    end
    if (doneL) begin
      fdL++;
      if (cntL != 4'd8) fdBad++;
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compCount++;
    assert (obs === exp) else begin
      errCount++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A pad shows bit n after n reads, and the pressed level once all 8 are gone
  function automatic logic expLine(input logic al, input logic [7:0] w, input int n);
    if (n >= 8) return ~al;
    return w[n] ^ al;
  endfunction

  function automatic logic [7:0] expCnt(input int n);
    return (n > 8) ? 8'd8 : 8'(n);
  endfunction

  task automatic checkFrame(input string tag, input logic [7:0] w, input int n);
    check({tag, ".lineH"}, {7'b0, dataH}, {7'b0, expLine(1'b1, w, n)});
    check({tag, ".lineL"}, {7'b0, dataL}, {7'b0, expLine(1'b0, w, n)});
    check({tag, ".cntH"}, {4'b0, cntH}, expCnt(n));
    check({tag, ".cntL"}, {4'b0, cntL}, expCnt(n));
  endtask

  task automatic checkErr(input string tag, input logic e);
    check({tag, ".errH"}, {7'b0, errH}, {7'b0, e});
    check({tag, ".errL"}, {7'b0, errL}, {7'b0, e});
  endtask

  task automatic latchStrobe();
    GLatch = 1'b1;
    repeat (4) @(negedge Clock);
    GLatch = 1'b0;
    repeat (4) @(negedge Clock);
  endtask

  task automatic pulseStrobe();
    GPulse = 1'b1;
    repeat (4) @(negedge Clock);
    GPulse = 1'b0;
    repeat (4) @(negedge Clock);
  endtask

  initial begin
    logic [7:0] w;
    logic [7:0] w2;
    int np;
    int fdStartH;
    int fdStartL;

    // Reset values
    repeat (3) @(negedge Clock);
    check("rst.lineH", {7'b0, dataH}, 8'd1);
    check("rst.lineL", {7'b0, dataL}, 8'd0);
    check("rst.cntH", {4'b0, cntH}, 8'd0);
    check("rst.doneH", {7'b0, doneH}, 8'd0);
    checkErr("rst", 1'b0);
    Reset = 1'b1;
    repeat (2) @(negedge Clock);

    // Pulses before any latch are ignored
    pulseStrobe();
    check("idle.lineH", {7'b0, dataH}, 8'd1);
    check("idle.lineL", {7'b0, dataL}, 8'd0);
    check("idle.cntH", {4'b0, cntH}, 8'd0);
    checkErr("idle", 1'b0);

    // Directed A5 frame, nine reads
    w = 8'hA5;
    Buttons = w;
    fdStartH = fdH;
    fdStartL = fdL;
    latchStrobe();
    checkFrame("a5.p0", w, 0);
    for (int i = 1; i <= 9; i++) begin
      pulseStrobe();
      checkFrame($sformatf("a5.p%0d", i), w, i);
      if (i == 8 || i == 9) begin
        check($sformatf("a5.fdH%0d", i), 8'(fdH - fdStartH), 8'd1);
        check($sformatf("a5.fdL%0d", i), 8'(fdL - fdStartL), 8'd1);
      end
    end
    checkErr("a5", 1'b0);

    // Random frames with mid-frame button changes that must not leak in
    for (int f = 0; f < 8; f++) begin
      w = 8'($urandom);
      Buttons = w;
      fdStartH = fdH;
      fdStartL = fdL;
      latchStrobe();
      checkFrame($sformatf("rnd%0d.p0", f), w, 0);
      Buttons = 8'($urandom);
      np = $urandom_range(10, 1);
      for (int i = 1; i <= np; i++) begin
        pulseStrobe();
        if (i == 2) Buttons = 8'($urandom);
        checkFrame($sformatf("rnd%0d.p%0d", f, i), w, i);
      end
      check($sformatf("rnd%0d.fdH", f), 8'(fdH - fdStartH), (np >= 8) ? 8'd1 : 8'd0);
      check($sformatf("rnd%0d.fdL", f), 8'(fdL - fdStartL), (np >= 8) ? 8'd1 : 8'd0);
      checkErr($sformatf("rnd%0d", f), 1'b0);
    end

    // Transparent load while latch is high, then frozen on release
    Buttons = 8'h00;
    GLatch = 1'b1;
    repeat (4) @(negedge Clock);
    check("xp.lineH0", {7'b0, dataH}, 8'd1);
    check("xp.lineL0", {7'b0, dataL}, 8'd0);
    Buttons = 8'h01;
    repeat (4) @(negedge Clock);
    check("xp.lineH1", {7'b0, dataH}, 8'd0);
    check("xp.lineL1", {7'b0, dataL}, 8'd1);
    check("xp.cntL", {4'b0, cntL}, 8'd0);
    GLatch = 1'b0;
    repeat (4) @(negedge Clock);
    Buttons = 8'hFF;
    repeat (2) @(negedge Clock);
    checkFrame("xp.frz", 8'h01, 0);
    for (int i = 1; i <= 3; i++) begin
      pulseStrobe();
      checkFrame($sformatf("xp.p%0d", i), 8'h01, i);
    end

    // Pulse during latch: error, no shift; sticky until the next latch rise
    Buttons = 8'h5A;
    GLatch = 1'b1;
    repeat (4) @(negedge Clock);
    GPulse = 1'b1;
    repeat (4) @(negedge Clock);
    checkErr("lderr", 1'b1);
    check("lderr.cntH", {4'b0, cntH}, 8'd0);
    GPulse = 1'b0;
    repeat (4) @(negedge Clock);
    GLatch = 1'b0;
    repeat (4) @(negedge Clock);
    checkErr("lderr.sticky", 1'b1);
    checkFrame("lderr.frame", 8'h5A, 0);
    GLatch = 1'b1;
    repeat (4) @(negedge Clock);
    checkErr("lderr.clr", 1'b0);
    GLatch = 1'b0;
    repeat (4) @(negedge Clock);

    // Reset mid-frame takes effect immediately
    w = 8'($urandom);
    Buttons = w;
    latchStrobe();
    for (int i = 1; i <= 4; i++) pulseStrobe();
    checkFrame("mid.p4", w, 4);
    Reset = 1'b0;
    #1;
    check("mid.rst.lineH", {7'b0, dataH}, 8'd1);
    check("mid.rst.lineL", {7'b0, dataL}, 8'd0);
    check("mid.rst.cntH", {4'b0, cntH}, 8'd0);
    check("mid.rst.doneH", {7'b0, doneH}, 8'd0);
    checkErr("mid.rst", 1'b0);
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    pulseStrobe();
    pulseStrobe();
    check("postrst.lineH", {7'b0, dataH}, 8'd1);
    check("postrst.lineL", {7'b0, dataL}, 8'd0);
    check("postrst.cntH", {4'b0, cntH}, 8'd0);
    check("postrst.cntL", {4'b0, cntL}, 8'd0);
    checkErr("postrst", 1'b0);

    // Latch and pulse together in SHIFT, with two-edge latency measurement
    w = 8'($urandom);
    Buttons = w;
    latchStrobe();
    for (int i = 1; i <= 3; i++) pulseStrobe();
    checkFrame("sim.p3", w, 3);
    w2 = ~w;
    Buttons = w2;
    GLatch = 1'b1;
    GPulse = 1'b1;
    @(posedge Clock);
    @(posedge Clock);
    #1;
    check("sim.lat1.cntH", {4'b0, cntH}, 8'd3);
    checkErr("sim.lat1", 1'b0);
    @(posedge Clock);
    #1;
    check("sim.lat2.cntH", {4'b0, cntH}, 8'd0);
    check("sim.lat2.cntL", {4'b0, cntL}, 8'd0);
    check("sim.lat2.lineH", {7'b0, dataH}, {7'b0, w2[0] ^ 1'b1});
    check("sim.lat2.lineL", {7'b0, dataL}, {7'b0, w2[0]});
    checkErr("sim.lat2", 1'b1);
    repeat (3) @(negedge Clock);
    GLatch = 1'b0;
    GPulse = 1'b0;
    repeat (4) @(negedge Clock);
    checkFrame("sim.after", w2, 0);
    checkErr("sim.after", 1'b1);

    check("fd.width", 8'(fdBad), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
    $finish;
  end

endmodule
